bram_stream_reader: RTL and testbench
=====================================

# bram_stream_reader

Sequential read engine for one port of a 2K×9 dual-port block RAM (RAMB16_S9_S9 port B, read-only). It fetches a programmed run of bytes with parity from a start address and presents them as a valid/ready byte stream with a last-byte marker. It sits between the block RAM and any byte-stream consumer, such as a UART/SPI transmitter or the video fetcher. It absorbs the RAM's one-cycle read latency with a two-entry skid buffer, so a continuously ready sink receives one byte per clock.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address width; run length is ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8, data bits per word; parity is 1 extra bit.

Ports:
- clk  in  1  single clock; the RAM port clock is this same clk.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- start_addr  in  11  first RAM address, sampled with start.
- length  in  12  bytes to read, 0..2048, sampled with start.
- abort  in  1  cancels the current run.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse after the last byte handshake.
- ram_en  out  1  RAM port enable, to ENB; WEB and SSRB are tied 0 externally.
- ram_addr  out  11  RAM address, to ADDRB.
- ram_dout  in  8  RAM read data, from DOB.
- ram_doutp  in  1  RAM parity, from DOPB.
- m_valid  out  1  stream byte valid.
- m_ready  in  1  sink accepts the byte.
- m_data  out  8  stream byte.
- m_parity  out  1  parity bit of the byte.
- m_last  out  1  qualifies the final byte of the run.

## Operation
States:
- IDLE
  - start=1 with length≠0: latch the address and length, go to RUN.
  - start=1 with length=0: pulse done the next cycle, stay IDLE, issue no RAM access.
- RUN: issue reads and drain the buffer. When the last byte is handshaken (m_valid & m_ready & m_last), go to IDLE.

Counters:
- Address counter: increments per issued read and wraps 2047→0. A run of 2048 from address 5 ends at address 4.
- Issue counter: counts remaining reads.
- Output counter: counts remaining bytes; m_last=1 when it equals 1.

Read issue:
- ram_en=1 only in RUN while reads remain and buffer occupancy + in-flight reads − (m_valid & m_ready) < 2.
- The buffer never overflows. The flow-control case "RAM data arrives with a full buffer" cannot occur and is asserted against in simulation.

Buffer:
- Two-entry FIFO of {parity, data}.
- A RAM word is written the cycle after its ram_en, because RAM latency is 1.
- m_data, m_parity and m_valid come from the head entry.
- m_data and m_parity stay stable while m_valid=1 and m_ready=0.

Other rules:
- start during RUN is ignored.
- abort has priority over everything. On abort, in the next cycle: state=IDLE, buffer flushed, m_valid=0, ram_en=0. The in-flight RAM word is discarded. No done pulse.
- abort in IDLE has no effect. abort and start in the same IDLE cycle: abort wins and the start is dropped.

## Timing
- Reset: busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_data=0, m_parity=0, m_last=0; state IDLE. Reset mid-run behaves like abort, but immediately.
- Start accepted at clock edge E0:
  - busy=1 and ram_en=1 with ram_addr=start_addr after E0.
  - The RAM word is registered at E2.
  - m_valid=1 after E2, so latency from start to first m_valid is 3 edges.
- Sustained throughput is 1 byte per clock with m_ready held high.
- After m_ready deasserts, at most 2 bytes are buffered and issue stalls. Refill restarts the same cycle m_ready returns; there are no bubbles after the first byte.
- done=1 and busy=0 in the cycle after the last handshake. A new start is accepted in that same cycle.

## Test plan
- Preload RAM[0x010..0x013]=0x11,0x22,0x33,0x44 with parity 1,0,1,0. Apply start, addr=0x010, len=4, m_ready=1. Expect 4 consecutive beats 0x11..0x44 with parity 1,0,1,0, m_last only on 0x44, and done one cycle later.
- Wrap: addr=0x7FE, len=4. Expect ram_addr sequence 0x7FE, 0x7FF, 0x000, 0x001 and the data in that order.
- Backpressure: len=8 with m_ready toggling 1,0,0,1,... Expect no dropped or duplicated bytes, data stable while stalled, and at most 2 RAM reads ahead of the sink.
- len=0: expect done pulse, no ram_en, m_valid never high. Then len=2048 with m_ready=1: expect exactly 2048 beats on consecutive cycles.
- Abort on the 3rd beat of a len=16 run: expect m_valid=0 and busy=0 the next cycle, no done, and a following start of len=2 streaming correct data.
- rst_n low mid-run: all outputs reach reset values immediately, and the next start behaves normally.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Sequential block-RAM read engine: fetches a programmed run of bytes (with parity) from one
// read-only RAM port and presents them as a valid/ready stream through a two-entry skid buffer.
module bram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_doutp,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_parity,
    output logic                  m_last
);

    localparam int unsigned EntryWidth = DATA_WIDTH + 1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     issue_q, issue_d;
    logic [ADDR_WIDTH:0]     out_q, out_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [EntryWidth-1:0]   ent0_q, ent0_d;
    logic [EntryWidth-1:0]   ent1_q, ent1_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    done_q, done_d;

    logic                    pop;
    logic [2:0]              occ;
    logic [EntryWidth-1:0]   ent_in;

    assign m_valid  = (cnt_q != 2'd0);
    assign pop      = m_valid & m_ready;
    assign m_data   = ent0_q[DATA_WIDTH-1:0];
    assign m_parity = ent0_q[DATA_WIDTH];
    assign m_last   = m_valid & (out_q == {{ADDR_WIDTH{1'b0}}, 1'b1});
    assign busy     = (state_q == StRun);
    assign done     = done_q;
    assign ram_addr = addr_q;
    assign ent_in   = {ram_doutp, ram_dout};

    // Buffered words plus the word in flight, less the one leaving now, must stay below two.
    assign occ    = {1'b0, cnt_q} + {2'b00, rd_pend_q};
    assign ram_en = (state_q == StRun) && !abort && (issue_q != '0) &&
                    (occ < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        issue_d   = issue_q;
        out_d     = out_q;
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        rd_pend_d = ram_en;

        unique case (cnt_q)
            2'd0: begin
                if (rd_pend_q) begin
                    ent0_d = ent_in;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (pop && rd_pend_q) begin
                    ent0_d = ent_in;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end else if (rd_pend_q) begin
                    ent1_d = ent_in;
                    cnt_d  = 2'd2;
                end
            end
            2'd2: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    if (rd_pend_q) begin
                        ent1_d = ent_in;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase

        if (ram_en) begin
            addr_d  = addr_q + 1'b1;
            issue_d = issue_q - 1'b1;
        end
        if (pop) begin
            out_d = out_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        addr_d  = start_addr;
                        issue_d = length;
                        out_d   = length;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    // The word still in flight is dropped by clearing its pending flag.
                    state_d   = StIdle;
                    cnt_d     = 2'd0;
                    rd_pend_d = 1'b0;
                end else if (pop && m_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            issue_q   <= '0;
            out_q     <= '0;
            rd_pend_q <= 1'b0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            cnt_q     <= 2'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            issue_q   <= issue_d;
            out_q     <= out_d;
            rd_pend_q <= rd_pend_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    no_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_pend_q && (cnt_q == 2'd2) && !pop));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised bench for bram_stream_reader: a run-level model (expected byte queue per command)
// is checked against the stream every cycle, plus literal checks from hand-computed runs.
module tb_bram_stream_reader;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic          clk, rst_n, start, abort, m_ready;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy, done, ram_en, ram_doutp, m_valid, m_parity, m_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout, m_data;

    bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
        .abort(abort), .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .ram_doutp(ram_doutp), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_parity(m_parity), .m_last(m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM port B: one-cycle registered read.
    bit [8:0] mem [DEPTH];
    initial begin
        ram_dout  = '0;
        ram_doutp = 1'b0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout  <= mem[ram_addr][7:0];
            ram_doutp <= mem[ram_addr][8];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level model.
    bit       run_m = 0;
    bit       done_m = 0;
    int       age_m, start_m, len_m, issued_m, acc_m;
    bit [8:0] exp_q[$];
    bit [9:0] hs_log[$];
    int       addr_log[$];
    int       cyc = 0;
    int       first_hs, last_hs;
    bit       prev_stall = 0;
    bit [8:0] prev_head;
    bit       vexp, hs;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_parity", m_parity, 0);
            chk("rst_m_last", m_last, 0);
            run_m = 0;
            done_m = 0;
            exp_q.delete();
            prev_stall = 0;
        end else begin
            // Once data arrives (3 edges after acceptance) the stream has no bubbles.
            vexp = run_m && (age_m >= 3);
            chk("busy", busy, run_m);
            chk("done", done, done_m);
            chk("m_valid", m_valid, vexp);
            if (vexp && exp_q.size() > 0) begin
                chk("m_data", m_data, exp_q[0][7:0]);
                chk("m_parity", m_parity, exp_q[0][8]);
                chk("m_last", m_last, exp_q.size() == 1);
            end
            if (prev_stall && m_valid) chk("stall_stable", {m_parity, m_data}, prev_head);
            prev_stall = m_valid && !m_ready;
            prev_head  = {m_parity, m_data};

            if (!run_m) begin
                chk("idle_ram_en", ram_en, 0);
            end else if (!abort) begin
                if (age_m == 1) chk("first_issue", ram_en, 1);
                if (ram_en) begin
                    chk("ram_addr", ram_addr, (start_m + issued_m) % DEPTH);
                    chk("issue_limit", issued_m < len_m, 1);
                    issued_m++;
                    addr_log.push_back(int'(ram_addr));
                end
            end

            hs = vexp && m_ready && exp_q.size() > 0;
            if (hs) begin
                hs_log.push_back({m_last, m_parity, m_data});
                void'(exp_q.pop_front());
                acc_m++;
                if (hs_log.size() == 1) first_hs = cyc;
                last_hs = cyc;
            end
            if (run_m && !abort) chk("reads_ahead", (issued_m - acc_m) <= 2, 1);

            if (abort) begin
                run_m = 0;
                exp_q.delete();
                done_m = 0;
            end else if (run_m) begin
                done_m = 0;
                if (hs && exp_q.size() == 0) begin
                    run_m  = 0;
                    done_m = 1;
                end
            end else begin
                done_m = 0;
                if (start) begin
                    if (length == 0) begin
                        done_m = 1;
                    end else begin
                        run_m = 1;
                        start_m = int'(start_addr);
                        len_m = int'(length);
                        issued_m = 0;
                        acc_m = 0;
                        age_m = 0;
                        for (int i = 0; i < len_m; i++) exp_q.push_back(mem[(start_m + i) % DEPTH]);
                    end
                end
            end
            age_m++;
        end
    end

    // Sink ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random.
    int rmode = 0;
    int rphase = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: m_ready = 1'b1;
            1: m_ready = (rphase % 3) == 0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        rphase++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int a, input int l);
        start = 1'b1;
        start_addr = AW'(a);
        length = (AW + 1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (run_m && n < limit) begin
            tick();
            n++;
        end
        chk(name, run_m, 0);
        tick();
        tick();
    endtask

    task automatic clear_logs();
        hs_log.delete();
        addr_log.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        start_addr = '0;
        length = '0;
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = 9'($urandom);
        mem[16] = 9'h111;
        mem[17] = 9'h022;
        mem[18] = 9'h133;
        mem[19] = 9'h044;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic run of four bytes.
        clear_logs();
        launch(16, 4);
        wait_idle(20, "basic_timeout");
        chk("basic_count", hs_log.size(), 4);
        if (hs_log.size() == 4) begin
            chk("basic_b0", hs_log[0], 10'h111);
            chk("basic_b1", hs_log[1], 10'h022);
            chk("basic_b2", hs_log[2], 10'h133);
            chk("basic_b3", hs_log[3], 10'h244);
            chk("basic_consecutive", last_hs - first_hs, 3);
        end

        // Address wrap.
        clear_logs();
        launch(12'h7FE, 4);
        wait_idle(20, "wrap_timeout");
        chk("wrap_n", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("wrap_a0", addr_log[0], 12'h7FE);
            chk("wrap_a1", addr_log[1], 12'h7FF);
            chk("wrap_a2", addr_log[2], 12'h000);
            chk("wrap_a3", addr_log[3], 12'h001);
        end

        // Backpressure, with an ignored start during the run.
        rmode = 1;
        clear_logs();
        launch(int'($urandom_range(0, DEPTH - 1)), 8);
        tick();
        start = 1'b1;
        length = 12'd5;
        tick();
        start = 1'b0;
        wait_idle(60, "bp_timeout");
        chk("bp_count", hs_log.size(), 8);

        // Zero length, then a full-size run from address 5.
        rmode = 0;
        clear_logs();
        launch(12'h123, 0);
        tick();
        tick();
        chk("len0_beats", hs_log.size(), 0);
        chk("len0_reads", addr_log.size(), 0);
        launch(5, 2048);
        wait_idle(2100, "full_timeout");
        chk("full_count", hs_log.size(), 2048);
        chk("full_consecutive", last_hs - first_hs, 2047);
        if (addr_log.size() == 2048) chk("full_last_addr", addr_log[2047], 4);

        // Abort on the third beat, then a clean short run.
        clear_logs();
        launch(12'h200, 16);
        begin
            int n = 0;
            while (acc_m < 2 && n < 50) begin
                tick();
                n++;
            end
            chk("abort_wait", acc_m >= 2, 1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_beats", hs_log.size(), 3);
        tick();
        clear_logs();
        launch(12'h300, 2);
        wait_idle(20, "post_abort_timeout");
        chk("post_abort_count", hs_log.size(), 2);

        // Abort and start together in idle: start dropped.
        abort = 1'b1;
        start = 1'b1;
        length = 12'd5;
        tick();
        abort = 1'b0;
        start = 1'b0;
        tick();
        tick();

        // Randomised runs with random sink and occasional aborts.
        rmode = 2;
        for (int r = 0; r < 25; r++) begin
            int k, n;
            launch(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)));
            k = int'($urandom_range(0, 60));
            n = 0;
            while (run_m && n < k) begin
                tick();
                n++;
            end
            if (run_m && $urandom_range(0, 2) == 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            wait_idle(300, "rand_timeout");
        end

        // Reset mid-run, then a normal run.
        rmode = 0;
        launch(12'h400, 50);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        launch(16, 4);
        wait_idle(20, "post_reset_timeout");
        chk("post_reset_count", hs_log.size(), 4);
        if (hs_log.size() == 4) chk("post_reset_last", hs_log[3], 10'h244);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
